// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multicycle_control
// Main controller for a multicycle RV32I-subset datapath. It is a Moore FSM
// that sequences fetch, decode and the per-class execute/memory/writeback
// states, plus a retired-instruction counter.
//
// Ports
//   clk          rising-edge clock for every register
//   rst_n        asynchronous active-low reset (forces FETCH, clears instret)
//   opcode       instr[6:0]
//   funct3       instr[14:12]
//   funct7_5     instr[30]
//   zero         ALU zero flag, consumed in the BEQ state
//   pc_write     PC load enable
//   adr_src      memory address mux (0 = PC, 1 = result)
//   mem_write    data memory write enable
//   ir_write     instruction / OldPC register load enable
//   result_src   result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   alu_src_a    ALU A mux (00 PC, 01 OldPC, 10 rd1)
//   alu_src_b    ALU B mux (00 rd2, 01 ImmExt, 10 constant 4)
//   alu_control  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src      immediate format select, decoded from opcode in every state
//   reg_write    register file write enable
//   state        current state encoding (debug)
//   instret      count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic        zero,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_control,
   output logic [2:0]  imm_src,
   output logic        reg_write,
   output logic [3:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      LUI      = 4'd11
   } stateT;

   localparam logic [6:0] opLoad   = 7'b0000011;
   localparam logic [6:0] opStore  = 7'b0100011;
   localparam logic [6:0] opRType  = 7'b0110011;
   localparam logic [6:0] opIType  = 7'b0010011;
   localparam logic [6:0] opBranch = 7'b1100011;
   localparam logic [6:0] opJal    = 7'b1101111;
   localparam logic [6:0] opJalr   = 7'b1100111;
   localparam logic [6:0] opLui    = 7'b0110111;
   localparam logic [6:0] opAuipc  = 7'b0010111;

   localparam logic [2:0] aluAdd = 3'b000;
   localparam logic [2:0] aluSub = 3'b001;
   localparam logic [2:0] aluAnd = 3'b010;
   localparam logic [2:0] aluOr  = 3'b011;
   localparam logic [2:0] aluSlt = 3'b101;

   stateT       stateReg;
   stateT       stateNext;
   logic [31:0] instretReg;
   logic [2:0]  aluDecoded;
   logic        retire;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= FETCH;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext = FETCH;
      case (stateReg)
         FETCH:   stateNext = DECODE;
         DECODE: begin
            case (opcode)
               opLoad, opStore: stateNext = MEMADR;
               opRType:         stateNext = EXECR;
               opIType:         stateNext = EXECI;
               opBranch:        stateNext = BEQ;
               opJal:           stateNext = JAL;
               opLui:           stateNext = LUI;
               default:         stateNext = FETCH;
            endcase
         end
         MEMADR:  stateNext = (opcode == opLoad) ? MEMREAD : MEMWRITE;
         MEMREAD: stateNext = MEMWB;
         EXECR:   stateNext = ALUWB;
         EXECI:   stateNext = ALUWB;
         JAL:     stateNext = ALUWB;
         default: stateNext = FETCH;
      endcase
   end

   // ALU operation for EXECR/EXECI. Only the register form uses funct7_5 to
   // pick sub, because for addi bit 30 is part of the immediate.
   always_comb begin
      aluDecoded = aluAdd;
      case (funct3)
         3'b000:  aluDecoded = ((stateReg == EXECR) && funct7_5) ? aluSub : aluAdd;
         3'b010:  aluDecoded = aluSlt;
         3'b110:  aluDecoded = aluOr;
         3'b111:  aluDecoded = aluAnd;
         default: aluDecoded = aluAdd;
      endcase
   end

   // Moore outputs
   always_comb begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = aluAdd;
      reg_write   = 1'b0;
      case (stateReg)
         FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            pc_write   = 1'b1;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         MEMREAD: begin
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = aluDecoded;
         end
         EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = aluDecoded;
         end
         ALUWB: begin
            reg_write = 1'b1;
         end
         BEQ: begin
            alu_src_a   = 2'b10;
            alu_control = aluSub;
            pc_write    = zero;
         end
         JAL: begin
            // Link value OldPC + 4; ALUOut still holds the target from DECODE.
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
         end
         LUI: begin
            // rd1 + ImmExt written straight from the ALU; rs1 field of a
            // U-type is expected to decode to x0 so the sum is ImmExt.
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            reg_write  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Immediate format depends only on opcode, independent of state.
   always_comb begin
      imm_src = 3'b111;
      case (opcode)
         opLoad, opIType, opJalr: imm_src = 3'b000;
         opStore:                 imm_src = 3'b001;
         opBranch:                imm_src = 3'b101;
         opLui, opAuipc:          imm_src = 3'b010;
         opJal:                   imm_src = 3'b110;
         default:                 imm_src = 3'b111;
      endcase
   end

   // An instruction retires on the edge leaving any final state for FETCH.
   // DECODE -> FETCH for an unsupported opcode is deliberately excluded.
   assign retire = (stateReg == MEMWB) || (stateReg == MEMWRITE) ||
                   (stateReg == ALUWB) || (stateReg == BEQ) ||
                   (stateReg == LUI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instretReg <= 32'd0;
      end else if (retire) begin
         instretReg <= instretReg + 32'd1;
      end
   end

   assign state   = stateReg;
   assign instret = instretReg;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

   logic        clk;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        zero;
   logic        pc_write;
   logic        adr_src;
   logic        mem_write;
   logic        ir_write;
   logic [1:0]  result_src;
   logic [1:0]  alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_control;
   logic [2:0]  imm_src;
   logic        reg_write;
   logic [3:0]  state;
   logic [31:0] instret;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] expInstret = 32'd0;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7_5(funct7_5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_src(imm_src), .reg_write(reg_write), .state(state), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClk;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [6:0] opTab[9];
      logic [2:0] immTab[9];
      opTab  = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
      immTab = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b101,
                 3'b010, 3'b010, 3'b110, 3'b111};
      rst_n = 1'b0; opcode = 7'b1111111; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b0;
      #2;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
      checks++;
      if ({pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_control, reg_write}
          !== {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0}) begin
         errors++;
         $display("FAIL reset_fetch_outputs: got pcw=%b adr=%b mw=%b irw=%b rs=%b a=%b b=%b alu=%b rw=%b expected 1 0 0 1 10 00 10 000 0",
                  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_control, reg_write);
      end
      // State is pinned in FETCH while reset is held, so sweep the immediate decode here.
      for (int i = 0; i < 9; i++) begin
         opcode = opTab[i];
         #1;
         checks++;
         if (imm_src !== immTab[i]) begin
            errors++;
            $display("FAIL imm_src[%b]: got %b expected %b", opTab[i], imm_src, immTab[i]);
         end
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_held_state: got %0d expected 0", state); end
      opcode = 7'b1111111;
      @(negedge clk);
      rst_n = 1'b1;
      stepClk();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL reset_release_state: got %0d expected 1", state); end
      stepClk();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_release_back: got %0d expected 0", state); end
      $display("reset: state=%0d instret=%0d", state, instret);
   endtask

   task automatic test_lw;
      int expSeq[6];
      expSeq = '{0, 1, 2, 3, 4, 0};
      opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) stepClk();
         checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, expSeq[i]); end
         checks++; if (reg_write !== (expSeq[i] == 4)) begin errors++; $display("FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, expSeq[i] == 4); end
         if (expSeq[i] == 2) begin
            checks++; if ({alu_src_a, alu_src_b} !== 4'b1001) begin errors++; $display("FAIL lw_memadr_src: got %b expected 1001", {alu_src_a, alu_src_b}); end
         end
         if (expSeq[i] == 3) begin
            checks++; if ({adr_src, result_src} !== 3'b100) begin errors++; $display("FAIL lw_memread: got %b expected 100", {adr_src, result_src}); end
         end
         if (expSeq[i] == 4) begin
            checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL lw_memwb_result_src: got %b expected 01", result_src); end
         end
         if (expSeq[i] == 1) begin
            checks++; if ({alu_src_a, alu_src_b, ir_write, pc_write} !== 6'b010100) begin errors++; $display("FAIL lw_decode_outputs: got %b expected 010100", {alu_src_a, alu_src_b, ir_write, pc_write}); end
         end
      end
      checks++; if (imm_src !== 3'b000) begin errors++; $display("FAIL lw_imm_src: got %b expected 000", imm_src); end
      expInstret++;
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL lw_instret: got %0d expected %0d", instret, expInstret); end
      $display("lw: instret=%0d", instret);
   endtask

   task automatic test_sw;
      int expSeq[5];
      int memWriteCycles;
      int regWriteCycles;
      expSeq = '{0, 1, 2, 5, 0};
      memWriteCycles = 0; regWriteCycles = 0;
      opcode = 7'b0100011; funct3 = 3'b010;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) stepClk();
         checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, expSeq[i]); end
         if (mem_write === 1'b1) memWriteCycles++;
         if (reg_write === 1'b1) regWriteCycles++;
         if (expSeq[i] == 5) begin
            checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL sw_adr_src: got %b expected 1", adr_src); end
         end
      end
      checks++; if (memWriteCycles != 1) begin errors++; $display("FAIL sw_mem_write_cycles: got %0d expected 1", memWriteCycles); end
      checks++; if (regWriteCycles != 0) begin errors++; $display("FAIL sw_reg_write_cycles: got %0d expected 0", regWriteCycles); end
      checks++; if (imm_src !== 3'b001) begin errors++; $display("FAIL sw_imm_src: got %b expected 001", imm_src); end
      expInstret++;
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL sw_instret: got %0d expected %0d", instret, expInstret); end
      $display("sw: instret=%0d", instret);
   endtask

   // Runs an ALU instruction through its execute state and checks the decode.
   task automatic test_alu_ops;
      logic [6:0] opTab[10];
      logic [2:0] f3Tab[10];
      logic       f7Tab[10];
      logic [2:0] expAlu[10];
      int         execState;
      int         expSeq[5];
      opTab  = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011};
      f3Tab  = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b100,
                 3'b000, 3'b010, 3'b110, 3'b111};
      f7Tab  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      expAlu = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000,
                 3'b000, 3'b101, 3'b011, 3'b010};
      for (int t = 0; t < 10; t++) begin
         opcode = opTab[t]; funct3 = f3Tab[t]; funct7_5 = f7Tab[t];
         execState = (opTab[t] == 7'b0110011) ? 6 : 7;
         expSeq = '{0, 1, execState, 8, 0};
         for (int i = 0; i < 5; i++) begin
            if (i > 0) stepClk();
            checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL alu%0d_state[%0d]: got %0d expected %0d", t, i, state, expSeq[i]); end
            if (i == 2) begin
               checks++; if (alu_control !== expAlu[t]) begin errors++; $display("FAIL alu%0d_control: got %b expected %b", t, alu_control, expAlu[t]); end
               checks++;
               if ({alu_src_a, alu_src_b} !== ((execState == 6) ? 4'b1000 : 4'b1001)) begin
                  errors++; $display("FAIL alu%0d_src: got %b expected %b", t, {alu_src_a, alu_src_b}, (execState == 6) ? 4'b1000 : 4'b1001);
               end
            end
            if (i == 3) begin
               checks++; if ({reg_write, result_src} !== 3'b100) begin errors++; $display("FAIL alu%0d_aluwb: got %b expected 100", t, {reg_write, result_src}); end
            end
         end
         expInstret++;
         checks++; if (instret !== expInstret) begin errors++; $display("FAIL alu%0d_instret: got %0d expected %0d", t, instret, expInstret); end
         $display("alu op %0d: opcode=%b funct3=%b f7=%b instret=%0d", t, opTab[t], f3Tab[t], f7Tab[t], instret);
      end
      funct7_5 = 1'b0;
   endtask

   task automatic test_beq;
      int expSeq[4];
      expSeq = '{0, 1, 9, 0};
      opcode = 7'b1100011; funct3 = 3'b000;
      for (int z = 1; z >= 0; z--) begin
         zero = z[0];
         for (int i = 0; i < 4; i++) begin
            if (i > 0) stepClk();
            checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL beq_z%0d_state[%0d]: got %0d expected %0d", z, i, state, expSeq[i]); end
            if (i == 2) begin
               checks++; if (pc_write !== z[0]) begin errors++; $display("FAIL beq_z%0d_pc_write: got %b expected %b", z, pc_write, z[0]); end
               checks++; if (alu_control !== 3'b001) begin errors++; $display("FAIL beq_alu_control: got %b expected 001", alu_control); end
            end
         end
         checks++; if (imm_src !== 3'b101) begin errors++; $display("FAIL beq_imm_src: got %b expected 101", imm_src); end
         expInstret++;
         checks++; if (instret !== expInstret) begin errors++; $display("FAIL beq_z%0d_instret: got %0d expected %0d", z, instret, expInstret); end
         $display("beq zero=%0d: instret=%0d", z, instret);
      end
      zero = 1'b0;
   endtask

   task automatic test_jal;
      int expSeq[5];
      expSeq = '{0, 1, 10, 8, 0};
      opcode = 7'b1101111;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) stepClk();
         checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, state, expSeq[i]); end
         if (i == 2) begin
            checks++; if ({pc_write, alu_src_a, alu_src_b, result_src} !== 7'b1011000) begin errors++; $display("FAIL jal_outputs: got %b expected 1011000", {pc_write, alu_src_a, alu_src_b, result_src}); end
         end
      end
      checks++; if (imm_src !== 3'b110) begin errors++; $display("FAIL jal_imm_src: got %b expected 110", imm_src); end
      expInstret++;
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL jal_instret: got %0d expected %0d", instret, expInstret); end
      $display("jal: instret=%0d", instret);
   endtask

   task automatic test_lui;
      int expSeq[4];
      expSeq = '{0, 1, 11, 0};
      opcode = 7'b0110111;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) stepClk();
         checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL lui_state[%0d]: got %0d expected %0d", i, state, expSeq[i]); end
         if (i == 2) begin
            checks++;
            if ({reg_write, result_src, alu_src_a, alu_src_b, alu_control, pc_write} !== 11'b1_10_10_01_000_0) begin
               errors++; $display("FAIL lui_outputs: got %b expected 11010010000", {reg_write, result_src, alu_src_a, alu_src_b, alu_control, pc_write});
            end
         end
      end
      checks++; if (imm_src !== 3'b010) begin errors++; $display("FAIL lui_imm_src: got %b expected 010", imm_src); end
      expInstret++;
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL lui_instret: got %0d expected %0d", instret, expInstret); end
      $display("lui: instret=%0d", instret);
   endtask

   task automatic test_unsupported;
      int expSeq[3];
      expSeq = '{0, 1, 0};
      opcode = 7'b1111111;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) stepClk();
         checks++; if (state !== 4'(expSeq[i])) begin errors++; $display("FAIL unsup_state[%0d]: got %0d expected %0d", i, state, expSeq[i]); end
      end
      checks++; if (imm_src !== 3'b111) begin errors++; $display("FAIL unsup_imm_src: got %b expected 111", imm_src); end
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL unsup_instret: got %0d expected %0d", instret, expInstret); end
      $display("unsupported: instret=%0d", instret);
   endtask

   task automatic test_reset_midinstr;
      opcode = 7'b0100011; funct3 = 3'b010;
      stepClk(); stepClk(); stepClk();
      checks++; if (state !== 4'd5) begin errors++; $display("FAIL midrst_reach_memwrite: got %0d expected 5", state); end
      rst_n = 1'b0;
      #1;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL midrst_state_async: got %0d expected 0", state); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL midrst_mem_write: got %b expected 0", mem_write); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL midrst_instret: got %0d expected 0", instret); end
      stepClk();
      checks++; if ({state, mem_write, reg_write} !== 6'b0000_00) begin errors++; $display("FAIL midrst_held: got %b expected 000000", {state, mem_write, reg_write}); end
      expInstret = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      stepClk();
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL midrst_release_state: got %0d expected 1", state); end
      checks++; if (instret !== expInstret) begin errors++; $display("FAIL midrst_release_instret: got %0d expected %0d", instret, expInstret); end
      $display("reset mid-instruction: state=%0d instret=%0d", state, instret);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_alu_ops();
      test_beq();
      test_jal();
      test_lui();
      test_unsupported();
      test_reset_midinstr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
